// File: rtl/dac_burst_detect.sv
// Transmit burst detector for the DAC sample stream.
// Finds burst start/end from sample activity and reports SOT/EOT pulses,
// a tx_active level, the length of the last completed burst and a burst count.
module dac_burst_detect #(
  parameter int unsigned MIN_GAP = 16,  // silent cycles before arming (1..65535)
  parameter int unsigned HOLD    = 8,   // silent cycles that end a burst (1..65535)
  parameter int unsigned THRESH  = 0    // magnitude threshold
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dac_enable,
  input  logic        dac_valid,
  input  logic [15:0] dac_data_i,
  input  logic [15:0] dac_data_q,
  output logic        dac_sot,
  output logic        dac_eot,
  output logic        tx_active,
  output logic [31:0] burst_len,
  output logic [15:0] burst_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam logic [15:0] THRESH_U  = 16'(THRESH);
  localparam logic [15:0] GAP_MAX   = 16'(MIN_GAP);
  localparam logic [15:0] GAP_LAST  = 16'(MIN_GAP - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD - 1);
  localparam logic [31:0] LEN_MAX   = 32'hFFFF_FFFF;

  // Magnitude of a two's complement sample; -32768 saturates to 32767.
  function automatic logic [15:0] sat_abs(input logic [15:0] x);
    if (!x[15])            return x;
    else if (x == 16'h8000) return 16'h7FFF;
    else                   return 16'(~x + 16'd1);
  endfunction

  state_e      state_q, state_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [31:0] len_acc_q, len_acc_d;
  logic [31:0] burst_len_q, burst_len_d;
  logic [15:0] burst_cnt_q, burst_cnt_d;
  logic        sot_q, sot_d;
  logic        eot_q, eot_d;
  logic        tx_active_q, tx_active_d;

  logic        act;
  logic [31:0] len_inc;

  // Sample activity: enabled, valid and above threshold on either rail.
  always_comb begin
    act = dac_enable & dac_valid &
          ((sat_abs(dac_data_i) > THRESH_U) | (sat_abs(dac_data_q) > THRESH_U));
  end

  // Next-state and next-output computation for the burst FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    len_acc_d   = len_acc_q;
    burst_len_d = burst_len_q;
    burst_cnt_d = burst_cnt_q;
    sot_d       = 1'b0;
    eot_d       = 1'b0;
    tx_active_d = tx_active_q;
    len_inc     = len_acc_q + {31'd0, (dac_valid && (len_acc_q != LEN_MAX))};

    unique case (state_q)
      IDLE: begin
        // tx_active stays high for the EOT cycle and drops here, one cycle later.
        tx_active_d = 1'b0;
        if (act) begin
          gap_cnt_d = '0;
        end else begin
          if (gap_cnt_q == GAP_LAST) state_d = ARMED;
          if (gap_cnt_q != GAP_MAX)  gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end

      ARMED: begin
        if (act) begin
          state_d     = ACTIVE;
          sot_d       = 1'b1;
          tx_active_d = 1'b1;
          burst_cnt_d = burst_cnt_q + 16'd1;
          len_acc_d   = 32'd1;
          hold_cnt_d  = '0;
        end
      end

      ACTIVE: begin
        len_acc_d = len_inc;
        // Enable drop wins over the hold timeout; both end the burst on this edge.
        if (!dac_enable || (!act && (hold_cnt_q == HOLD_LAST))) begin
          state_d     = IDLE;
          eot_d       = 1'b1;
          burst_len_d = len_inc;
          gap_cnt_d   = '0;
          hold_cnt_d  = '0;
        end else if (act) begin
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q     <= IDLE;
      gap_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      len_acc_q   <= '0;
      burst_len_q <= '0;
      burst_cnt_q <= '0;
      sot_q       <= 1'b0;
      eot_q       <= 1'b0;
      tx_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      len_acc_q   <= len_acc_d;
      burst_len_q <= burst_len_d;
      burst_cnt_q <= burst_cnt_d;
      sot_q       <= sot_d;
      eot_q       <= eot_d;
      tx_active_q <= tx_active_d;
    end
  end

  assign dac_sot   = sot_q;
  assign dac_eot   = eot_q;
  assign tx_active = tx_active_q;
  assign burst_len = burst_len_q;
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_dac_burst_detect.sv
// Directed testbench for dac_burst_detect: arming, hold timeout, enable drop,
// threshold edge values and reset mid-burst. Two instances share the inputs:
// dut uses THRESH=0, dut_t uses THRESH=200.
module tb_dac_burst_detect;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dac_enable = 1'b0;
  logic        dac_valid = 1'b0;
  logic [15:0] dac_data_i = '0;
  logic [15:0] dac_data_q = '0;

  logic        sot, eot, tx;
  logic [31:0] blen;
  logic [15:0] bcnt;
  logic        sot_t, eot_t, tx_t;
  logic [31:0] blen_t;
  logic [15:0] bcnt_t;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dac_burst_detect #(.MIN_GAP(16), .HOLD(8), .THRESH(0)) dut (
    .clk(clk), .rst(rst), .dac_enable(dac_enable), .dac_valid(dac_valid),
    .dac_data_i(dac_data_i), .dac_data_q(dac_data_q),
    .dac_sot(sot), .dac_eot(eot), .tx_active(tx),
    .burst_len(blen), .burst_cnt(bcnt)
  );

  dac_burst_detect #(.MIN_GAP(16), .HOLD(8), .THRESH(200)) dut_t (
    .clk(clk), .rst(rst), .dac_enable(dac_enable), .dac_valid(dac_valid),
    .dac_data_i(dac_data_i), .dac_data_q(dac_data_q),
    .dac_sot(sot_t), .dac_eot(eot_t), .tx_active(tx_t),
    .burst_len(blen_t), .burst_cnt(bcnt_t)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present one cycle of inputs; outputs are sampled 1ns after the edge.
  task automatic drive(input logic en, input logic v, input logic [15:0] i, input logic [15:0] q);
    dac_enable = en;
    dac_valid  = v;
    dac_data_i = i;
    dac_data_q = q;
    @(posedge clk);
    #1;
  endtask

  task automatic silent(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b1, 16'd0, 16'd0);
  endtask

  initial begin
    // Reset: two cycles.
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'd0, 16'd0);
    drive(1'b1, 1'b1, 16'd0, 16'd0);
    check("rst_sot", sot, 0);
    check("rst_eot", eot, 0);
    check("rst_tx", tx, 0);
    check("rst_len", blen, 0);
    check("rst_cnt", bcnt, 0);
    rst = 1'b0;

    // Arming after reset: 16 silent cycles, then a trigger sample.
    silent(16);
    check("arm_no_sot_silent", sot, 0);
    drive(1'b1, 1'b1, 16'd100, 16'd0);
    check("arm_sot", sot, 1);
    check("arm_cnt", bcnt, 1);
    check("arm_tx", tx, 1);
    check("thr_100_no_sot", sot_t, 0);
    // Threshold edge: |I|=|Q|=200 is not above 200.
    drive(1'b1, 1'b1, 16'd200, 16'hFF38);
    check("thr_200_no_sot", sot_t, 0);
    check("arm_sot_one_cycle", sot, 0);
    // I=-32768 saturates to 32767 and is active.
    drive(1'b1, 1'b1, 16'h8000, 16'd0);
    check("thr_min_sot", sot_t, 1);
    check("thr_min_cnt", bcnt_t, 1);

    // Not armed yet: trigger at 10 silent cycles after reset.
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'd0, 16'd0);
    rst = 1'b0;
    silent(10);
    drive(1'b1, 1'b1, 16'd5, 16'd0);
    check("early_no_sot", sot, 0);
    silent(16);
    drive(1'b1, 1'b1, 16'd5, 16'd0);
    check("late_sot", sot, 1);
    check("late_cnt", bcnt, 1);

    // Hold timeout: 49 active samples (incl. trigger) + 8 silent = 57 valid.
    for (int k = 0; k < 48; k++) drive(1'b1, 1'b1, 16'd300, 16'd0);
    silent(7);
    check("hold7_no_eot", eot, 0);
    check("hold7_tx", tx, 1);
    silent(1);
    check("hold8_eot", eot, 1);
    check("hold8_len", blen, 57);
    check("hold8_tx", tx, 1);
    silent(1);
    check("hold_eot_one_cycle", eot, 0);
    check("hold_tx_drop", tx, 0);

    // Re-trigger after 15 silent cycles: no SOT.
    silent(14);
    drive(1'b1, 1'b1, 16'd5, 16'd0);
    check("gap15_no_sot", sot, 0);
    silent(16);
    drive(1'b1, 1'b1, 16'd5, 16'd0);
    check("b2_sot", sot, 1);
    check("b2_cnt", bcnt, 2);

    // Enable drop with a 7-silent gap inside: 8 active + 7 silent + 5 active = 20.
    for (int k = 0; k < 7; k++) drive(1'b1, 1'b1, 16'hFFF0, 16'd0);
    silent(7);
    check("gap7_no_eot", eot, 0);
    check("gap7_tx", tx, 1);
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 16'd0, 16'd77);
    drive(1'b0, 1'b0, 16'd0, 16'd0);
    check("en_drop_eot", eot, 1);
    check("en_drop_len", blen, 20);
    drive(1'b1, 1'b1, 16'd0, 16'd0);
    check("en_drop_tx_low", tx, 0);
    check("en_drop_len_hold", blen, 20);
    silent(14);
    drive(1'b1, 1'b1, 16'd5, 16'd0);
    check("en_gap15_no_sot", sot, 0);
    silent(16);
    drive(1'b1, 1'b1, 16'd5, 16'd0);
    check("b3_sot", sot, 1);
    check("b3_cnt", bcnt, 3);

    // Shortest burst: enable drops right after SOT.
    drive(1'b0, 1'b0, 16'd0, 16'd0);
    check("short_eot", eot, 1);
    check("short_no_sot", sot, 0);
    check("short_len", blen, 1);

    // Reset mid-burst: no EOT, everything cleared.
    silent(16);
    drive(1'b1, 1'b1, 16'd5, 16'd0);
    check("b4_sot", sot, 1);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 16'd300, 16'd0);
    check("b4_tx", tx, 1);
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'd300, 16'd0);
    check("abort_sot", sot, 0);
    check("abort_eot", eot, 0);
    check("abort_tx", tx, 0);
    check("abort_len", blen, 0);
    check("abort_cnt", bcnt, 0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 16'd300, 16'd0);
    check("abort_no_eot_after", eot, 0);
    check("abort_no_sot_after", sot, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
